// File: rtl/fetch_pkg.sv
// Shared fetch/decode constants: ROM geometry, the halt opcode and the fetch state encoding.
// Decode imports the same package so both stages agree on HALT_OP.
package fetch_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    localparam logic [5:0] HALT_OP = 6'b111111;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    function automatic logic is_halt(input logic [DATA_W-1:0] word);
        return word[31:26] == HALT_OP;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, drives the one-cycle-latency ROM and presents
// each fetched word with its address to decode, with stall, redirect and halt.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_dout,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_STEP = 1;

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rd_pc;
    logic              rd_valid;
    logic              accept;
    logic              take_halt;

    // NOTE: reset is asynchronous, so it sits in the sensitivity list and wins over the clock.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Redirect overrides everything, including a halt accepted in the same cycle.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        if (redirect) begin
            next_state = RUN;
        end else begin
            unique case (state)
                BOOT:    next_state = RUN;
                RUN:     next_state = take_halt ? HALTED : RUN;
                HALTED:  next_state = HALTED;
                default: next_state = BOOT;
            endcase
        end
    end

    // While stalled the ROM re-reads rd_pc, so imem_dout stays put without a hold register.
    always_comb begin
        instr_valid = rd_valid && (state == RUN);
        halted      = (state == HALTED);
        accept      = instr_valid && !stall;
        take_halt   = accept && is_halt(imem_dout);
        imem_addr   = (stall && state == RUN) ? rd_pc : pc;
    end

    assign instr    = imem_dout;
    assign instr_pc = rd_pc;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            rd_pc    <= RESET_PC;
            rd_valid <= 1'b0;
        end else if (redirect) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            pc       <= redirect_addr;
            rd_valid <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    rd_pc    <= pc;
                    pc       <= pc + PC_STEP;
                    rd_valid <= 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        rd_pc    <= pc;
                        pc       <= pc + PC_STEP;
                        rd_valid <= !take_halt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by a
// randomized stall/redirect run checked against a transaction-level stream model.
module tb_instruction_fetch_unit;

    logic        clka = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [10:0] redirect_addr;
    logic [10:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] instr;
    logic [10:0] instr_pc;
    logic        instr_valid;
    logic        halted;

    int total = 0;
    int bad   = 0;

    logic [31:0] rom [0:2047];

    instruction_fetch_unit dut (
        .clka          (clka),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_addr     (imem_addr),
        .imem_dout     (imem_dout),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .halted        (halted)
    );

    always #5 clka = ~clka;

    // Single-port ROM with one-cycle registered read.
    always @(posedge clka) imem_dout <= rom[imem_addr];

    function automatic logic [31:0] image_word(input logic [10:0] a);
        if (a == 11'd10) return 32'hFC00_0000;
        return 32'h1000_0000 + {21'd0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic expect_instr(input string tag, input logic [10:0] a);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_pc"}, {21'd0, instr_pc}, {21'd0, a});
        check({tag, "_instr"}, instr, image_word(a));
    endtask

    task automatic release_reset();
        rst = 1'b0;
        #1;
        check("boot_valid", {31'd0, instr_valid}, 32'd0);
        check("boot_addr", {21'd0, imem_addr}, 32'd0);
        step();
        expect_instr("first", 11'd0);
    endtask

    logic [10:0] frozen_addr;
    logic [10:0] exp_next;
    logic [10:0] target;
    logic        expect_bubble;
    logic        prev_hold;
    int          n_acc;

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = image_word(11'(i));

        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_addr = '0;
        step();
        step();
        check("rst_addr", {21'd0, imem_addr}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", {21'd0, instr_pc}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);

        // Reset release: 0,1,2,...,5 on consecutive cycles
        release_reset();
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_instr("seq", 11'(i));
        end

        // Stall three edges while instr_pc=5
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            #1;
            check("stall_addr", {21'd0, imem_addr}, 32'd5);
            expect_instr("stall_hold", 11'd5);
            step();
        end
        expect_instr("stall_end", 11'd5);
        stall = 1'b0;
        step();
        expect_instr("post_stall", 11'd6);
        step();
        expect_instr("post_stall", 11'd7);

        // Redirect to 20 while instr_pc=8
        step();
        expect_instr("pre_redir", 11'd8);
        redirect = 1'b1;
        redirect_addr = 11'd20;
        #1;
        check("redir_not_comb", {21'd0, imem_addr}, 32'd9);
        step();
        redirect = 1'b0;
        check("redir_bubble", {31'd0, instr_valid}, 32'd0);
        step();
        expect_instr("redir_tgt", 11'd20);
        step();
        expect_instr("redir_tgt", 11'd21);

        // Redirect and stall together, target 3: redirect wins
        stall = 1'b1;
        redirect = 1'b1;
        redirect_addr = 11'd3;
        step();
        stall = 1'b0;
        redirect = 1'b0;
        check("rs_bubble", {31'd0, instr_valid}, 32'd0);
        step();
        expect_instr("rs_tgt", 11'd3);
        step();
        expect_instr("rs_tgt", 11'd4);

        // Run up to the halt word at 10 and accept it
        for (int i = 5; i <= 10; i++) begin
            step();
            expect_instr("to_halt", 11'(i));
        end
        step();
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        frozen_addr = imem_addr;
        for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom_range(0, 1));
            step();
            check("halt_frozen", {21'd0, imem_addr}, {21'd0, frozen_addr});
            check("halt_stay", {30'd0, halted, instr_valid}, 32'd2);
        end
        stall = 1'b0;
        redirect = 1'b1;
        redirect_addr = 11'd0;
        step();
        redirect = 1'b0;
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_bubble", {31'd0, instr_valid}, 32'd0);
        step();
        expect_instr("resume", 11'd0);

        // Wrap-around from 2046
        redirect = 1'b1;
        redirect_addr = 11'd2046;
        step();
        redirect = 1'b0;
        check("wrap_bubble", {31'd0, instr_valid}, 32'd0);
        step();
        expect_instr("wrap", 11'd2046);
        step();
        expect_instr("wrap", 11'd2047);
        step();
        expect_instr("wrap", 11'd0);
        step();
        expect_instr("wrap", 11'd1);

        // Asynchronous reset mid-stream, between edges
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_pc", {21'd0, instr_pc}, 32'd0);
        check("arst_addr", {21'd0, imem_addr}, 32'd0);
        step();
        step();
        release_reset();
        step();
        expect_instr("restart", 11'd1);

        // Randomized stall/redirect, checked against the expected accepted-address stream
        redirect = 1'b1;
        redirect_addr = 11'd100;
        exp_next = 11'd100;
        step();
        redirect = 1'b0;
        expect_bubble = 1'b1;
        prev_hold = 1'b0;
        n_acc = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (expect_bubble) begin
                check("rnd_bubble", {31'd0, instr_valid}, 32'd0);
            end else begin
                if (prev_hold) check("rnd_hold", {31'd0, instr_valid}, 32'd1);
                if (instr_valid) begin
                    check("rnd_pc", {21'd0, instr_pc}, {21'd0, exp_next});
                    check("rnd_instr", instr, image_word(exp_next));
                end
            end
            stall = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 15) == 0);
            target = 11'($urandom_range(100, 1500));
            redirect_addr = target;
            prev_hold = instr_valid && stall && !redirect;
            if (instr_valid && !stall) begin
                exp_next = instr_pc + 11'd1;
                n_acc++;
            end
            expect_bubble = redirect;
            if (redirect) exp_next = target;
            step();
        end
        stall = 1'b0;
        redirect = 1'b0;
        check("rnd_progress", {31'd0, n_acc > 100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
